// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the MIPS-subset control path: FSM state encoding,
// primary opcodes and the datapath mux/ALU select encodings.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_RD    = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WR    = 4'd6,
        ST_R_EXEC    = 4'd7,
        ST_R_WB      = 4'd8,
        ST_ADDI_EXEC = 4'd9,
        ST_ADDI_WB   = 4'd10,
        ST_BRANCH    = 4'd11,
        ST_JUMP      = 4'd12,
        ST_TRAP      = 4'd13
    } state_t;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_R_TYPE = 6'b000000;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_J      = 6'b000010;

    // ALU B-operand select
    localparam logic [1:0] SRC_B_REG      = 2'b00;
    localparam logic [1:0] SRC_B_FOUR     = 2'b01;
    localparam logic [1:0] SRC_B_IMM      = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SHL2 = 2'b11;

    // ALU operation class
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // PC input select
    localparam logic [1:0] PC_SRC_ALU     = 2'b00;
    localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

    // Dispatch from DECODE: unknown opcodes fall into the absorbing trap state
    function automatic state_t decode_dispatch(input logic [5:0] op);
        case (op)
            OP_R_TYPE:    return ST_R_EXEC;
            OP_LW, OP_SW: return ST_MEM_ADDR;
            OP_ADDI:      return ST_ADDI_EXEC;
            OP_BNE:       return ST_BRANCH;
            OP_J:         return ST_JUMP;
            default:      return ST_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle main control FSM: sequences fetch / decode / execute / memory /
// write-back over a shared memory port and ALU. Moore outputs, gated only by
// mem_ready (memory states) and alu_zero (branch).
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] op_code,
    input  logic       mem_ready,
    input  logic       alu_zero,
    output logic       pc_write,
    output logic       ior_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       trap
);

    state_t state_reg;
    state_t state_next;

    // State register; reset forces IDLE immediately, which zeroes every output
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; memory states hold until mem_ready is sampled high
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      state_next = ST_FETCH;
            ST_FETCH:     state_next = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE:    state_next = decode_dispatch(op_code);
            ST_MEM_ADDR:  state_next = (op_code == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:    state_next = mem_ready ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WB:    state_next = ST_FETCH;
            ST_MEM_WR:    state_next = mem_ready ? ST_FETCH : ST_MEM_WR;
            ST_R_EXEC:    state_next = ST_R_WB;
            ST_R_WB:      state_next = ST_FETCH;
            ST_ADDI_EXEC: state_next = ST_ADDI_WB;
            ST_ADDI_WB:   state_next = ST_FETCH;
            ST_BRANCH:    state_next = ST_FETCH;
            ST_JUMP:      state_next = ST_FETCH;
            ST_TRAP:      state_next = ST_TRAP;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Output decode; every control not driven in a state stays 0
    always_comb begin
        pc_write   = 1'b0;
        ior_d      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_REG;
        alu_op     = ALU_OP_ADD;
        pc_source  = PC_SRC_ALU;
        instr_done = 1'b0;
        trap       = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                // PC + 4 computed while the instruction is read
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                // Speculative branch target into ALUOut
                alu_src_b = SRC_B_IMM_SHL2;
            end
            ST_MEM_ADDR, ST_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                ior_d    = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write  = 1'b1;
                ior_d      = 1'b1;
                instr_done = mem_ready;
            end
            ST_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_FUNCT;
            end
            ST_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            ST_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ST_BRANCH: begin
                // bne: take the ALUOut target only when operands differ
                alu_src_a  = 1'b1;
                alu_op     = ALU_OP_SUB;
                pc_source  = PC_SRC_ALU_OUT;
                pc_write   = !alu_zero;
                instr_done = 1'b1;
            end
            ST_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PC_SRC_JUMP;
                instr_done = 1'b1;
            end
            ST_TRAP: begin
                trap = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle vector table of
// {op_code, mem_ready, alu_zero, expected outputs}, plus hand-written
// sequences for trap persistence and asynchronous reset mid-access.
module tb_multicycle_control;

    logic       clock;
    logic       reset_n;
    logic [5:0] op_code;
    logic       mem_ready;
    logic       alu_zero;
    logic       pc_write, ior_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, trap;

    int total;
    int bad;

    multicycle_control dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .op_code    (op_code),
        .mem_ready  (mem_ready),
        .alu_zero   (alu_zero),
        .pc_write   (pc_write),
        .ior_d      (ior_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .instr_done (instr_done),
        .trap       (trap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observed outputs packed as
    // {pc_write, ior_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
    //  reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, trap}
    logic [16:0] got;
    assign got = {pc_write, ior_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, trap};

    //                            pw   ior  mr   mw   irw  rd   m2r  rw   asa  asb    aop    pcs    done trap
    localparam logic [16:0] E_ZERO  = 17'd0;
    localparam logic [16:0] E_F0    = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
    localparam logic [16:0] E_F1    = {1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
    localparam logic [16:0] E_DEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0};
    localparam logic [16:0] E_MA    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
    localparam logic [16:0] E_MR    = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [16:0] E_MWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
    localparam logic [16:0] E_MW0   = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [16:0] E_MW1   = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
    localparam logic [16:0] E_RX    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0};
    localparam logic [16:0] E_RWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
    localparam logic [16:0] E_AWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
    localparam logic [16:0] E_BR_T  = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1,1'b0};
    localparam logic [16:0] E_BR_N  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1,1'b0};
    localparam logic [16:0] E_JMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b1,1'b0};
    localparam logic [16:0] E_TRAP  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1};

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic        az;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [5:0] op, input logic mr, input logic az,
                                input logic [16:0] exp);
        vec_t v;
        v.op  = op;
        v.mr  = mr;
        v.az  = az;
        v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [16:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%05h want=%05h", name, got, exp);
        end
    endtask

    // Drive one cycle's inputs just after a rising edge, compare mid-cycle,
    // then advance to just after the next rising edge.
    task automatic step(input string name, input logic [5:0] op, input logic mr,
                        input logic az, input logic [16:0] exp);
        op_code   = op;
        mem_ready = mr;
        alu_zero  = az;
        @(negedge clock);
        check(name, exp);
        $display("cycle %s op=%b mr=%b az=%b out=%05h", name, op, mr, az, got);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        total     = 0;
        bad       = 0;
        op_code   = 6'b0;
        mem_ready = 1'b0;
        alu_zero  = 1'b0;
        reset_n   = 1'b0;

        // Main table: one entry per clock cycle from the first IDLE cycle
        vecs.push_back(mk(6'b000000, 1'b1, 1'b0, E_ZERO));  // IDLE
        // R-type (op changes after DECODE must be ignored)
        vecs.push_back(mk(6'b000000, 1'b1, 1'b0, E_F1));
        vecs.push_back(mk(6'b000000, 1'b1, 1'b0, E_DEC));
        vecs.push_back(mk(6'b111111, 1'b0, 1'b0, E_RX));
        vecs.push_back(mk(6'b111111, 1'b0, 1'b0, E_RWB));
        // lw: FETCH waits 2, MEM_RD waits 3 -> 10 cycles
        vecs.push_back(mk(6'b000000, 1'b0, 1'b0, E_F0));
        vecs.push_back(mk(6'b000000, 1'b0, 1'b0, E_F0));
        vecs.push_back(mk(6'b100011, 1'b1, 1'b0, E_F1));
        vecs.push_back(mk(6'b100011, 1'b0, 1'b0, E_DEC));
        vecs.push_back(mk(6'b100011, 1'b0, 1'b0, E_MA));
        vecs.push_back(mk(6'b100011, 1'b0, 1'b0, E_MR));
        vecs.push_back(mk(6'b100011, 1'b0, 1'b0, E_MR));
        vecs.push_back(mk(6'b100011, 1'b0, 1'b0, E_MR));
        vecs.push_back(mk(6'b100011, 1'b1, 1'b0, E_MR));
        vecs.push_back(mk(6'b100011, 1'b0, 1'b0, E_MWB));
        // bne taken (alu_zero=0)
        vecs.push_back(mk(6'b000101, 1'b1, 1'b0, E_F1));
        vecs.push_back(mk(6'b000101, 1'b0, 1'b0, E_DEC));
        vecs.push_back(mk(6'b000101, 1'b0, 1'b0, E_BR_T));
        // bne not taken (alu_zero=1)
        vecs.push_back(mk(6'b000101, 1'b1, 1'b1, E_F1));
        vecs.push_back(mk(6'b000101, 1'b1, 1'b1, E_DEC));
        vecs.push_back(mk(6'b000101, 1'b1, 1'b1, E_BR_N));
        // sw with 2 wait cycles, then j back-to-back
        vecs.push_back(mk(6'b101011, 1'b1, 1'b0, E_F1));
        vecs.push_back(mk(6'b101011, 1'b0, 1'b0, E_DEC));
        vecs.push_back(mk(6'b101011, 1'b1, 1'b0, E_MA));
        vecs.push_back(mk(6'b101011, 1'b0, 1'b0, E_MW0));
        vecs.push_back(mk(6'b101011, 1'b0, 1'b0, E_MW0));
        vecs.push_back(mk(6'b101011, 1'b1, 1'b0, E_MW1));
        vecs.push_back(mk(6'b000010, 1'b1, 1'b0, E_F1));
        vecs.push_back(mk(6'b000010, 1'b0, 1'b0, E_DEC));
        vecs.push_back(mk(6'b000010, 1'b0, 1'b0, E_JMP));
        // addi
        vecs.push_back(mk(6'b001000, 1'b1, 1'b0, E_F1));
        vecs.push_back(mk(6'b001000, 1'b0, 1'b0, E_DEC));
        vecs.push_back(mk(6'b001000, 1'b0, 1'b0, E_MA));
        vecs.push_back(mk(6'b001000, 1'b0, 1'b0, E_AWB));
        // illegal opcode
        vecs.push_back(mk(6'b111111, 1'b1, 1'b0, E_F1));
        vecs.push_back(mk(6'b111111, 1'b0, 1'b0, E_DEC));

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("reset_hold", E_ZERO);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].op, vecs[i].mr, vecs[i].az, vecs[i].exp);
        end

        // Trap must persist regardless of inputs
        for (int i = 0; i < 20; i++) begin
            step($sformatf("trap%0d", i), 6'($urandom_range(0, 63)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), E_TRAP);
        end

        // Reset clears trap, then IDLE -> FETCH
        reset_n = 1'b0;
        #1;
        check("trap_reset", E_ZERO);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step("post_trap_idle", 6'b000000, 1'b1, 1'b0, E_ZERO);
        step("post_trap_fetch", 6'b100011, 1'b1, 1'b0, E_F1);

        // lw interrupted by reset during the MEM_RD wait
        step("rst_dec", 6'b100011, 1'b0, 1'b0, E_DEC);
        step("rst_ma", 6'b100011, 1'b0, 1'b0, E_MA);
        mem_ready = 1'b0;
        @(negedge clock);
        check("rst_mr_wait", E_MR);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_cycle", E_ZERO);
        @(posedge clock);
        #1;
        check("rst_after_edge", E_ZERO);
        reset_n = 1'b1;
        step("rst_idle", 6'b000000, 1'b1, 1'b0, E_ZERO);
        step("rst_fetch", 6'b000000, 1'b0, 1'b0, E_F0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
